// File: rtl/ball_centroid_if.sv
// Pixel-stream and result signals between the detector, ball_centroid and the VGA side.
// The master modport is the upstream/observer side; the slave modport is ball_centroid itself.
interface ball_centroid_if;
    logic        h_sync;
    logic        v_sync;
    logic [9:0]  h_value;
    logic [8:0]  v_value;
    logic        white_pixel;
    logic [23:0] video_in;
    logic        marker_en;
    logic [23:0] video_out;
    logic [9:0]  centre_x;
    logic [8:0]  centre_y;
    logic        centre_valid;
    logic        centre_update;
    logic [18:0] pixel_count;
    logic        overrun;

    modport master (
        output h_sync, v_sync, h_value, v_value, white_pixel, video_in, marker_en,
        input  video_out, centre_x, centre_y, centre_valid, centre_update, pixel_count, overrun
    );

    modport slave (
        input  h_sync, v_sync, h_value, v_value, white_pixel, video_in, marker_en,
        output video_out, centre_x, centre_y, centre_valid, centre_update, pixel_count, overrun
    );
endinterface

// File: rtl/ball_centroid.sv
// Accumulates qualifying pixel coordinates per frame, divides during vertical blanking
// to find the object centre, and overlays a "+" marker at that centre on the video.
//
// state | meaning
// IDLE  | waiting for a frame end
// LOAD  | operands latched, check pixel count against MIN_PIXELS
// DIV_X | restoring division sum_x / cnt, one quotient bit per cycle
// DIV_Y | restoring division sum_y / cnt, one quotient bit per cycle
// DONE  | publish results, pulse centre_update
module ball_centroid #(
    parameter int unsigned ARM          = 8,
    parameter logic [23:0] MARKER_COLOR = 24'h00FF00,
    parameter int unsigned MIN_PIXELS   = 16,
    parameter int unsigned SUM_W        = 28
) (
    input logic            ball_clock,
    input logic            reset_n,
    ball_centroid_if.slave bus
);
    localparam int unsigned CNT_W = 19;
    localparam int unsigned BIT_W = $clog2(SUM_W);
    localparam logic signed [10:0] ARM_S = 11'(ARM);

    typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, DONE} state_t;

    state_t state_q, state_d;

    logic             v_sync_dly_q, v_sync_dly_d;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] op_x_q, op_x_d, op_y_q, op_y_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [SUM_W-1:0] rem_q, rem_d, quot_q, quot_d;
    logic [9:0]       qx_q, qx_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [9:0]       centre_x_q, centre_x_d;
    logic [8:0]       centre_y_q, centre_y_d;
    logic             centre_valid_q, centre_valid_d;
    logic [CNT_W-1:0] pixel_count_q, pixel_count_d;
    logic             overrun_q, overrun_d;
    logic [23:0]      video_out_q, video_out_d;

    logic             frame_end, qual, busy, bit_tc, cnt_ok, centre_update;
    logic [SUM_W:0]   rem_shift;
    logic [SUM_W-1:0] div_ext, rem_sub, rem_next, quot_next;
    logic             ge;
    logic signed [10:0] dx, dy;
    logic             marker;

    assign frame_end = ~bus.v_sync & v_sync_dly_q;
    assign qual      = bus.h_sync & bus.v_sync & bus.white_pixel;
    assign bit_tc    = (bit_q == '0);
    assign cnt_ok    = (op_cnt_q >= CNT_W'(MIN_PIXELS));

    // One restoring-division step; the remainder always stays below the divisor,
    // so SUM_W-bit modular subtraction is exact whenever ge is set.
    always_comb begin
        rem_shift = {rem_q, quot_q[SUM_W-1]};
        div_ext   = {{(SUM_W-CNT_W){1'b0}}, op_cnt_q};
        ge        = (rem_shift >= {1'b0, div_ext});
        rem_sub   = rem_shift[SUM_W-1:0] - div_ext;
        rem_next  = ge ? rem_sub : rem_shift[SUM_W-1:0];
        quot_next = {quot_q[SUM_W-2:0], ge};
    end

    always_ff @(posedge ball_clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_end) state_d = LOAD;
            LOAD:    state_d = cnt_ok ? DIV_X : DONE;
            DIV_X:   if (bit_tc) state_d = DIV_Y;
            DIV_Y:   if (bit_tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        centre_update = (state_q == DONE);
    end

    always_comb begin
        v_sync_dly_d   = bus.v_sync;
        sum_x_d        = sum_x_q;
        sum_y_d        = sum_y_q;
        cnt_d          = cnt_q;
        op_x_d         = op_x_q;
        op_y_d         = op_y_q;
        op_cnt_d       = op_cnt_q;
        rem_d          = rem_q;
        quot_d         = quot_q;
        qx_d           = qx_q;
        bit_d          = bit_q;
        centre_x_d     = centre_x_q;
        centre_y_d     = centre_y_q;
        centre_valid_d = centre_valid_q;
        pixel_count_d  = pixel_count_q;
        overrun_d      = frame_end & busy;

        if (frame_end) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
            if (!busy) begin
                op_x_d   = sum_x_q;
                op_y_d   = sum_y_q;
                op_cnt_d = cnt_q;
            end
        end else if (qual) begin
            sum_x_d = sum_x_q + {{(SUM_W-10){1'b0}}, bus.h_value};
            sum_y_d = sum_y_q + {{(SUM_W-9){1'b0}}, bus.v_value};
            cnt_d   = cnt_q + CNT_W'(1);
        end

        case (state_q)
            LOAD: begin
                rem_d  = '0;
                quot_d = op_x_q;
                bit_d  = BIT_W'(SUM_W - 1);
            end
            DIV_X: begin
                rem_d  = rem_next;
                quot_d = quot_next;
                bit_d  = bit_q - BIT_W'(1);
                if (bit_tc) begin
                    qx_d   = quot_next[9:0];
                    rem_d  = '0;
                    quot_d = op_y_q;
                    bit_d  = BIT_W'(SUM_W - 1);
                end
            end
            DIV_Y: begin
                rem_d  = rem_next;
                quot_d = quot_next;
                bit_d  = bit_q - BIT_W'(1);
            end
            DONE: begin
                pixel_count_d = op_cnt_q;
                if (cnt_ok) begin
                    centre_x_d     = qx_q;
                    centre_y_d     = quot_q[8:0];
                    centre_valid_d = 1'b1;
                end else begin
                    centre_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Overlay reads the live centre; it only changes in DONE, which is during blanking.
    always_comb begin
        dx     = $signed({1'b0, bus.h_value}) - $signed({1'b0, centre_x_q});
        dy     = $signed({2'b0, bus.v_value}) - $signed({2'b0, centre_y_q});
        marker = bus.marker_en & centre_valid_q & bus.h_sync & bus.v_sync &
                 (((dy == 11'sd0) && (dx >= -ARM_S) && (dx <= ARM_S)) ||
                  ((dx == 11'sd0) && (dy >= -ARM_S) && (dy <= ARM_S)));
        video_out_d = marker ? MARKER_COLOR : bus.video_in;
    end

    always_ff @(posedge ball_clock or negedge reset_n) begin
        if (!reset_n) begin
            v_sync_dly_q   <= 1'b0;
            sum_x_q        <= '0;
            sum_y_q        <= '0;
            cnt_q          <= '0;
            op_x_q         <= '0;
            op_y_q         <= '0;
            op_cnt_q       <= '0;
            rem_q          <= '0;
            quot_q         <= '0;
            qx_q           <= '0;
            bit_q          <= '0;
            centre_x_q     <= '0;
            centre_y_q     <= '0;
            centre_valid_q <= 1'b0;
            pixel_count_q  <= '0;
            overrun_q      <= 1'b0;
            video_out_q    <= '0;
        end else begin
            v_sync_dly_q   <= v_sync_dly_d;
            sum_x_q        <= sum_x_d;
            sum_y_q        <= sum_y_d;
            cnt_q          <= cnt_d;
            op_x_q         <= op_x_d;
            op_y_q         <= op_y_d;
            op_cnt_q       <= op_cnt_d;
            rem_q          <= rem_d;
            quot_q         <= quot_d;
            qx_q           <= qx_d;
            bit_q          <= bit_d;
            centre_x_q     <= centre_x_d;
            centre_y_q     <= centre_y_d;
            centre_valid_q <= centre_valid_d;
            pixel_count_q  <= pixel_count_d;
            overrun_q      <= overrun_d;
            video_out_q    <= video_out_d;
        end
    end

    assign bus.video_out     = video_out_q;
    assign bus.centre_x      = centre_x_q;
    assign bus.centre_y      = centre_y_q;
    assign bus.centre_valid  = centre_valid_q;
    assign bus.centre_update = centre_update;
    assign bus.pixel_count   = pixel_count_q;
    assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_ball_centroid.sv
// Self-checking bench for ball_centroid: frames are synthetic pixel lists, expected centres
// come from plain integer averaging, overlay expectations from the "+" geometry.
module tb_ball_centroid;
    localparam logic [23:0] GREEN = 24'h00FF00;

    logic ball_clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 ball_clock = ~ball_clock;
    always @(posedge ball_clock) cyc <= cyc + 1;

    ball_centroid_if bus ();
    ball_centroid dut (.ball_clock(ball_clock), .reset_n(reset_n), .bus(bus));

    typedef struct {int h; int v; bit hs; bit white;} pix_t;
    typedef struct {int h; int v; bit hs; bit en; logic [23:0] vid; logic [23:0] exp_out;} ovl_vec_t;

    pix_t frame_q[$];
    int   m_cx = 0, m_cy = 0, m_cnt = 0;
    bit   m_valid = 0;

    task automatic chk(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ball_clock);
        #1;
    endtask

    task automatic drive(int h, int v, bit hs, bit vs, bit w, bit en, logic [23:0] vid);
        bus.h_value     = 10'(h);
        bus.v_value     = 9'(v);
        bus.h_sync      = hs;
        bus.v_sync      = vs;
        bus.white_pixel = w;
        bus.marker_en   = en;
        bus.video_in    = vid;
    endtask

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic logic [23:0] exp_video(int h, int v, bit hs, bit en, logic [23:0] vid);
        if (en && m_valid && hs &&
            ((v == m_cy && iabs(h - m_cx) <= 8) || (h == m_cx && iabs(v - m_cy) <= 8)))
            return GREEN;
        return vid;
    endfunction

    task automatic model_frame();
        longint sx = 0, sy = 0;
        int cnt = 0;
        foreach (frame_q[i]) if (frame_q[i].hs && frame_q[i].white) begin
            sx += frame_q[i].h;
            sy += frame_q[i].v;
            cnt++;
        end
        m_cnt = cnt;
        m_valid = (cnt >= 16);
        if (m_valid) begin
            m_cx = int'(sx / cnt);
            m_cy = int'(sy / cnt);
        end
    endtask

    task automatic play_frame(output int n);
        foreach (frame_q[i]) begin
            drive(frame_q[i].h, frame_q[i].v, frame_q[i].hs, 1'b1, frame_q[i].white, 1'b1, 24'($urandom));
            tick();
        end
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        n = cyc;
    endtask

    task automatic run_frame(string name);
        int n, lat;
        model_frame();
        play_frame(n);
        lat = -1;
        for (int k = 0; k < 200 && lat < 0; k++) begin
            @(negedge ball_clock);
            if (bus.centre_update) lat = cyc - n;
        end
        chk({name, " latency"}, lat, m_valid ? 58 : 2);
        @(negedge ball_clock);
        chk({name, " update_pulse_len"}, bus.centre_update, 0);
        chk({name, " centre_x"}, bus.centre_x, m_cx);
        chk({name, " centre_y"}, bus.centre_y, m_cy);
        chk({name, " centre_valid"}, bus.centre_valid, m_valid);
        chk({name, " pixel_count"}, bus.pixel_count, m_cnt);
        tick();
    endtask

    task automatic random_frame(int max_pix, bit all_white);
        int np;
        frame_q.delete();
        np = $urandom_range(max_pix, 0);
        for (int i = 0; i < np; i++)
            frame_q.push_back('{h: $urandom_range(639, 0), v: $urandom_range(479, 0),
                                hs: all_white || ($urandom_range(3, 0) != 0),
                                white: all_white || ($urandom_range(2, 0) != 0)});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ovl_vec_t vecs[$];
        int n, upd_c, ov_c, ov_cnt, upd_cnt, h, v;
        bit hs, en;
        logic [23:0] vid;

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 24'h0);
        repeat (3) tick();
        chk("reset video_out", bus.video_out, 0);
        chk("reset centre_x", bus.centre_x, 0);
        chk("reset centre_y", bus.centre_y, 0);
        chk("reset centre_valid", bus.centre_valid, 0);
        chk("reset centre_update", bus.centre_update, 0);
        chk("reset pixel_count", bus.pixel_count, 0);
        chk("reset overrun", bus.overrun, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        frame_q.delete();
        repeat (16) frame_q.push_back('{h: 100, v: 50, hs: 1, white: 1});
        frame_q.push_back('{h: 5, v: 5, hs: 1, white: 0});
        run_frame("point100_50");

        frame_q.delete();
        for (int y = 200; y < 210; y++)
            for (int x = 300; x < 310; x++) frame_q.push_back('{h: x, v: y, hs: 1, white: 1});
        frame_q.push_back('{h: 639, v: 479, hs: 0, white: 1});
        run_frame("block10x10");

        frame_q.delete();
        repeat (15) frame_q.push_back('{h: 50, v: 60, hs: 1, white: 1});
        run_frame("fifteen_pixels");

        frame_q.delete();
        for (int i = 0; i < 30; i++) frame_q.push_back('{h: i, v: i, hs: 1, white: 0});
        run_frame("black_frame");

        for (int r = 0; r < 6; r++) begin
            random_frame(60, 1'b0);
            run_frame($sformatf("rand%0d", r));
        end

        frame_q.delete();
        repeat (16) frame_q.push_back('{h: 2, v: 3, hs: 1, white: 1});
        run_frame("centre2_3");

        vecs = '{
            '{h: 0,  v: 3,  hs: 1, en: 1, vid: 24'h111111, exp_out: GREEN},
            '{h: 10, v: 3,  hs: 1, en: 1, vid: 24'h222222, exp_out: GREEN},
            '{h: 11, v: 3,  hs: 1, en: 1, vid: 24'h333333, exp_out: 24'h333333},
            '{h: 2,  v: 0,  hs: 1, en: 1, vid: 24'h444444, exp_out: GREEN},
            '{h: 2,  v: 11, hs: 1, en: 1, vid: 24'h555555, exp_out: GREEN},
            '{h: 2,  v: 12, hs: 1, en: 1, vid: 24'h666666, exp_out: 24'h666666},
            '{h: 2,  v: 3,  hs: 1, en: 1, vid: 24'h777777, exp_out: GREEN},
            '{h: 5,  v: 5,  hs: 1, en: 1, vid: 24'h888888, exp_out: 24'h888888},
            '{h: 3,  v: 4,  hs: 1, en: 1, vid: 24'h999999, exp_out: 24'h999999},
            '{h: 2,  v: 3,  hs: 0, en: 1, vid: 24'hAAAAAA, exp_out: 24'hAAAAAA},
            '{h: 2,  v: 3,  hs: 1, en: 0, vid: 24'hBBBBBB, exp_out: 24'hBBBBBB},
            '{h: 10, v: 3,  hs: 1, en: 0, vid: 24'hCCCCCC, exp_out: 24'hCCCCCC}
        };
        foreach (vecs[i]) begin
            drive(vecs[i].h, vecs[i].v, vecs[i].hs, 1'b1, 1'b0, vecs[i].en, vecs[i].vid);
            tick();
            chk($sformatf("overlay_vec%0d", i), bus.video_out, vecs[i].exp_out);
        end

        for (int i = 0; i < 150; i++) begin
            h = $urandom_range(14, 0);
            v = $urandom_range(14, 0);
            hs = ($urandom_range(4, 0) != 0);
            en = ($urandom_range(4, 0) != 0);
            vid = 24'($urandom);
            drive(h, v, hs, 1'b1, 1'b0, en, vid);
            tick();
            chk($sformatf("overlay_rand h=%0d v=%0d", h, v), bus.video_out, exp_video(h, v, hs, en, vid));
        end

        // Overrun: second frame end lands 20 cycles after the first, inside DIV_X.
        random_frame(30, 1'b1);
        repeat (20) frame_q.push_back('{h: 320, v: 240, hs: 1, white: 1});
        model_frame();
        play_frame(n);
        upd_c = -1; ov_c = -1; ov_cnt = 0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (c < 20) drive(600, 400, 1'b1, 1'b1, 1'b1, 1'b1, 24'h0);
            else        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
            @(negedge ball_clock);
            if (bus.centre_update && upd_c < 0) upd_c = c;
            if (bus.overrun) begin ov_cnt++; ov_c = c; end
        end
        tick();
        chk("overrun latency", upd_c, 58);
        chk("overrun pulse count", ov_cnt, 1);
        chk("overrun pulse cycle", ov_c, 21);
        chk("overrun centre_x", bus.centre_x, m_cx);
        chk("overrun centre_y", bus.centre_y, m_cy);
        chk("overrun pixel_count", bus.pixel_count, m_cnt);
        random_frame(30, 1'b1);
        repeat (16) frame_q.push_back('{h: 10, v: 10, hs: 1, white: 1});
        run_frame("after_overrun");

        // Reset asserted while the divider is in DIV_Y.
        random_frame(30, 1'b1);
        repeat (16) frame_q.push_back('{h: 500, v: 100, hs: 1, white: 1});
        play_frame(n);
        repeat (40) tick();
        reset_n = 1'b0;
        #1;
        chk("midreset video_out", bus.video_out, 0);
        chk("midreset centre_x", bus.centre_x, 0);
        chk("midreset centre_y", bus.centre_y, 0);
        chk("midreset centre_valid", bus.centre_valid, 0);
        chk("midreset centre_update", bus.centre_update, 0);
        chk("midreset pixel_count", bus.pixel_count, 0);
        m_cx = 0; m_cy = 0; m_valid = 0; m_cnt = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        upd_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge ball_clock);
            if (bus.centre_update) upd_cnt++;
        end
        chk("midreset no update", upd_cnt, 0);
        tick();
        random_frame(40, 1'b1);
        repeat (16) frame_q.push_back('{h: 200, v: 300, hs: 1, white: 1});
        run_frame("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ball_centroid.md
Name: ball_centroid

Overview:
- Consumes the per-pixel low-pass-filtered white/red decision and the pixel row/column counters produced by the detector stage.
- Accumulates the coordinates of all qualifying pixels across one frame, then computes the object centre with an iterative divider during vertical blanking.
- Overlays a "+" marker at the centre onto the outgoing VGA video.
- Sits directly downstream of the detector, between it and the VGA generator.

Parameters:
- ARM, 8: marker half-length in pixels.
- MARKER_COLOR, 24'h00FF00: RGB value drawn for marker pixels.
- MIN_PIXELS, 16: minimum qualifying pixels per frame for a valid centre.
- SUM_W, 28: width of the coordinate accumulators and the divider.

Ports:
- ball_clock  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- h_sync  in  1  high during the active part of a line.
- v_sync  in  1  high during the active part of a frame.
- h_value  in  10  column 0..639.
- v_value  in  9  row 0..479.
- white_pixel  in  1  filtered pixel decision, aligned with h_value/v_value.
- video_in  in  24  RGB camera video, aligned with h_value/v_value.
- marker_en  in  1  enables the overlay.
- video_out  out  24  video with marker, registered.
- centre_x  out  10  centre column.
- centre_y  out  9  centre row.
- centre_valid  out  1  last completed frame met MIN_PIXELS.
- centre_update  out  1  one-cycle pulse when results are refreshed.
- pixel_count  out  19  qualifying pixel count of the last completed frame.
- overrun  out  1  one-cycle pulse when a frame end arrives while the divider is busy.

Behaviour:
- Reset (async, reset_n=0): all registers clear. video_out=0, centre_x=0, centre_y=0, centre_valid=0, centre_update=0, pixel_count=0, overrun=0. FSM goes to IDLE. Registered v_sync_d=0, so no false edge is detected after reset release.
- Accumulate:
  - Qualifier each cycle: h_sync & v_sync & white_pixel.
  - When qualified: sum_x += h_value, sum_y += v_value, cnt += 1.
  - Widths: SUM_W bits for the sums, 19 bits for cnt. Maximums (639*307200, 307200) fit, so there is no saturation logic.
- Frame end: detected in the cycle where v_sync=0 and v_sync_d=1. In that same cycle:
  - If FSM is IDLE: copy sum_x, sum_y and cnt into the divider operand registers.
  - Clear the accumulators.
  - A qualifying pixel cannot coincide with frame end because v_sync=0.
- FSM states: IDLE, LOAD, DIV_X, DIV_Y, DONE.
  - IDLE -> LOAD on frame end.
  - LOAD (1 cycle):
    - If cnt < MIN_PIXELS, including cnt=0: go to DONE with the invalid flag set and no division.
    - Otherwise go to DIV_X.
  - DIV_X: restoring division sum_x/cnt, one quotient bit per cycle, exactly SUM_W cycles, then DIV_Y.
  - DIV_Y: same for sum_y/cnt, SUM_W cycles, then DONE.
  - DONE (1 cycle), then IDLE. In DONE:
    - pixel_count <= cnt.
    - centre_update=1.
    - If valid: centre_x <= quotient_x[9:0], centre_y <= quotient_y[8:0], centre_valid <= 1.
    - If invalid: centre_valid <= 0 and centre_x/centre_y hold their previous values.
  - Quotients truncate (floor). The divider never sees cnt=0.
- Latency (frame-end detect in cycle N):
  - Valid frame: centre_update asserted in cycle N+2+2*SUM_W, i.e. N+58 at default.
  - Invalid frame: centre_update asserted in cycle N+2.
- Overrun: a frame end while FSM is not IDLE causes:
  - a pulse on overrun;
  - accumulators cleared, with that frame's data discarded;
  - the divider continuing undisturbed.
- Overlay (1-cycle registered latency from video_in/h_value/v_value):
  - A pixel is a marker pixel when marker_en & centre_valid & h_sync & v_sync, and either:
    - v_value==centre_y and |h_value−centre_x|<=ARM, or
    - h_value==centre_x and |v_value−centre_y|<=ARM.
  - Differences use signed 11-bit arithmetic. There is no wrap; off-screen arm parts are simply not drawn.
  - video_out = MARKER_COLOR for marker pixels, otherwise video_in.
  - The overlay uses the centre registers live; an update in DONE occurs during blanking, so there is no tearing.
- Reset mid-division: aborts immediately to IDLE. No centre_update is generated for the interrupted frame.

Test Plan:
- Single frame with exactly one white pixel at (100,50) and MIN_PIXELS=1 -> centre_x=100, centre_y=50, centre_valid=1, pixel_count=1, centre_update one cycle at N+58.
- 10x10 white block covering x 300..309, y 200..209 -> pixel_count=100, centre_x=304, centre_y=204 (truncated 304.5), centre_valid=1.
- Frame with 15 white pixels (MIN_PIXELS=16) following a valid frame -> centre_valid=0, centre_x/centre_y unchanged, centre_update at N+2. An all-black frame gives the same result with pixel_count=0.
- Centre (2,3), ARM=8, marker_en=1 -> row 3 columns 0..10 and column 2 rows 0..11 output 24'h00FF00 one cycle after their inputs. Column 11 and all other pixels pass video_in. With marker_en=0, all pixels pass video_in.
- Second v_sync falling edge 20 cycles after the first, during DIV_X -> overrun pulses once. First frame's result is still delivered at N+58; second frame's data is dropped.
- reset_n asserted during DIV_Y -> all outputs 0 immediately, no centre_update. The next full frame produces a correct centre.
